error_stats_monitor: RTL

ERROR_STATS_MONITOR -- requirements
Module: error_stats_monitor

---
 rtl/error_stats_monitor_pkg.sv | 22 ++
 rtl/error_stats_monitor_abs_err_stage.sv | 57 +++++
 rtl/error_stats_monitor.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/error_stats_monitor_pkg.sv
//------------------------------------------------------------------------------
// error_stats_monitor_pkg
// Shared state encoding and default sizing for the error statistics monitor.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package error_stats_monitor_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_ACC_W = 48;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/error_stats_monitor_abs_err_stage.sv
//------------------------------------------------------------------------------
// abs_err_stage
// Registers the absolute error between an approximate sum and the exact sum.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

import error_stats_monitor_pkg::*;

module abs_err_stage #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_accept,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH:0]   i_approx,
  output logic             o_valid,
  output logic [WIDTH:0]   o_exact,
  output logic [WIDTH:0]   o_err
);

  logic [WIDTH:0] w_exact;
  logic [WIDTH:0] w_err;
  logic           r_valid;
  logic [WIDTH:0] r_exact;
  logic [WIDTH:0] r_err;

  always_comb begin
    w_exact = {1'b0, i_a} + {1'b0, i_b};
    w_err   = (i_approx >= w_exact) ? (i_approx - w_exact) : (w_exact - i_approx);
  end

  // Flush wins over a same-cycle accept so the sample is dropped entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_exact <= '0;
      r_err   <= '0;
    end else begin
      r_valid <= i_accept & ~i_flush;
      if (i_accept) begin
        r_exact <= w_exact;
        r_err   <= w_err;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_exact = r_exact;
  assign o_err   = r_err;

endmodule

`default_nettype wire

// File: rtl/error_stats_monitor.sv
//------------------------------------------------------------------------------
// error_stats_monitor
// Accumulates saturating error statistics of an approximate adder, with snapshot handshake.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

import error_stats_monitor_pkg::*;

module error_stats_monitor #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_approx,
  input  logic             clear,
  input  logic             stat_req,
  output logic             stat_valid,
  input  logic             stat_ack,
  output logic [CNT_W-1:0] stat_count,
  output logic [CNT_W-1:0] stat_err_count,
  output logic [WIDTH:0]   stat_max_err,
  output logic [ACC_W-1:0] stat_sum_err
);

  localparam int SUM_W = ((ACC_W > WIDTH + 1) ? ACC_W : WIDTH + 1) + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_ready;
  logic             w_snap;
  logic             w_clear_run;
  logic             w_accept;
  logic             w_s1_valid;
  logic [WIDTH:0]   w_s1_exact;
  logic [WIDTH:0]   w_s1_err;
  logic [SUM_W-1:0] w_sum_ext;
  logic [ACC_W-1:0] w_sum_nxt;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_err_count;
  logic [WIDTH:0]   r_max_err;
  logic [ACC_W-1:0] r_sum_err;
  logic [CNT_W-1:0] r_snap_count;
  logic [CNT_W-1:0] r_snap_err_count;
  logic [WIDTH:0]   r_snap_max_err;
  logic [ACC_W-1:0] r_snap_sum_err;

  assign w_clear_run = clear & (r_state == ST_RUN);
  assign w_accept    = in_valid & w_in_ready;

  abs_err_stage #(.WIDTH(WIDTH)) u_abs_err_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_accept (w_accept),
    .i_flush  (w_clear_run),
    .i_a      (in_a),
    .i_b      (in_b),
    .i_approx (in_approx),
    .o_valid  (w_s1_valid),
    .o_exact  (w_s1_exact),
    .o_err    (w_s1_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_snap      = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_in_ready = 1'b1;
        if (!clear && stat_req) w_state_nxt = ST_DRAIN;
      end
      // Wait for the in-flight sample to land in the accumulators first.
      ST_DRAIN: begin
        if (!w_s1_valid) begin
          w_snap      = 1'b1;
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (stat_ack) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_sum_ext = SUM_W'(r_sum_err) + SUM_W'(w_s1_err);
    w_sum_nxt = (w_sum_ext > SUM_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_err_count <= '0;
      r_max_err   <= '0;
      r_sum_err   <= '0;
    end else if (w_clear_run) begin
      r_count     <= '0;
      r_err_count <= '0;
      r_max_err   <= '0;
      r_sum_err   <= '0;
    end else if (w_s1_valid) begin
      if (r_count != '1) r_count <= r_count + 1'b1;
      if ((w_s1_err != '0) && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
      if (w_s1_err > r_max_err) r_max_err <= w_s1_err;
      r_sum_err <= w_sum_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_count     <= '0;
      r_snap_err_count <= '0;
      r_snap_max_err   <= '0;
      r_snap_sum_err   <= '0;
    end else if (w_snap) begin
      r_snap_count     <= r_count;
      r_snap_err_count <= r_err_count;
      r_snap_max_err   <= r_max_err;
      r_snap_sum_err   <= r_sum_err;
    end
  end

  // The exact sum is carried for debug visibility only; fold it into a no-op.
  logic w_unused;
  assign w_unused = ^w_s1_exact;

  assign in_ready       = w_in_ready & ~w_unused | w_in_ready & w_unused;
  assign stat_valid     = (r_state == ST_REPORT);
  assign stat_count     = r_snap_count;
  assign stat_err_count = r_snap_err_count;
  assign stat_max_err   = r_snap_max_err;
  assign stat_sum_err   = r_snap_sum_err;

endmodule

`default_nettype wire
